// File: rtl/epi_tracer_pkg.sv
// Shared constants and push/pull case codes for the LCI tracer queue.
package epi_tracer_pkg;

   localparam int DEPTH_DEFAULT  = 16;
   localparam int PULL_W_DEFAULT = 2;

   // {pull active, push accepted}
   typedef enum logic [1:0] {
      CASE_NN = 2'b00,
      CASE_NP = 2'b01,
      CASE_PN = 2'b10,
      CASE_PP = 2'b11
   } pp_case_e;

endpackage

// File: rtl/epi_tracer_lci_head_enc.sv
// Priority encoder: position (plus one) of the lowest set bit, 0 when none set.
module epi_tracer_lci_head_enc
   import epi_tracer_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH-1:0] vec_i,
   output logic [CNT_W-1:0] len_o
);

   // Scan from the tail down so the lowest set index wins.
   always_comb begin
      len_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec_i[i]) len_o = CNT_W'(i + 1);
      end
   end

endmodule

// File: rtl/epi_tracer_lci_queue.sv
// Shift-register queue of last-child-instruction flags with multi-entry commit.
module epi_tracer_lci_queue
   import epi_tracer_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int PULL_W = PULL_W_DEFAULT,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PN_W  = $clog2(PULL_W + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             last_i,
   input  logic [PN_W-1:0]  pull_n_i,
   output logic [DEPTH-1:0] lci_vec_o,
   output logic [DEPTH-1:0] valid_vec_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] head_grp_len_o,
   output logic [CNT_W-1:0] grp_cnt_o,
   output logic             overflow_o,
   output logic             underflow_o
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DEPTH-1:0] lci_q, lci_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [CNT_W-1:0] pull_req;
   logic [CNT_W-1:0] pe;
   logic [CNT_W-1:0] remain;
   logic             accept;
   pp_case_e         pp_case;

   // Place a new flag at the given slot; the slot is always below DEPTH when used.
   function automatic logic [DEPTH-1:0] write_tail(input logic [DEPTH-1:0] v,
                                                   input logic [CNT_W-1:0] idx,
                                                   input logic             bit_in);
      logic [DEPTH-1:0] r;
      r = v;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) == idx) r[i] = bit_in;
      end
      return r;
   endfunction

   // Decode push/pull into one of four cases and compute the next queue image.
   always_comb begin
      pull_req = CNT_W'(pull_n_i);
      pe       = (pull_req > count_q) ? count_q : pull_req;
      remain   = count_q - pe;
      accept   = push_i && (remain < DEPTH_C);
      pp_case  = pp_case_e'({pe != '0, accept});

      lci_d   = lci_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;

      if (flush_i) begin
         lci_d   = '0;
         count_d = '0;
      end else begin
         ovf_d = ovf_q | (push_i & ~accept);
         unf_d = unf_q | (pull_req > count_q);
         // Invalid slots already hold 0, so a plain right shift drops the
         // committed head entries and back-fills with invalid zeros.
         unique case (pp_case)
            CASE_NN: ;
            CASE_NP: begin
               lci_d   = write_tail(lci_q, remain, last_i);
               count_d = count_q + ONE;
            end
            CASE_PN: begin
               lci_d   = lci_q >> pe;
               count_d = remain;
            end
            CASE_PP: begin
               lci_d   = write_tail(lci_q >> pe, remain, last_i);
               count_d = remain + ONE;
            end
            default: ;
         endcase
      end

      for (int i = 0; i < DEPTH; i++) begin
         valid_d[i] = CNT_W'(i) < count_d;
      end
   end

   // State registers; reset discards every entry and clears the sticky flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lci_q   <= '0;
         valid_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         lci_q   <= lci_d;
         valid_q <= valid_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   epi_tracer_lci_head_enc #(
      .DEPTH (DEPTH)
   ) u_head_enc (
      .vec_i (lci_q & valid_q),
      .len_o (head_grp_len_o)
   );

   assign lci_vec_o   = lci_q;
   assign valid_vec_o = valid_q;
   assign count_o     = count_q;
   assign full_o      = (count_q == DEPTH_C);
   assign empty_o     = (count_q == '0);
   assign grp_cnt_o   = CNT_W'($countones(lci_q & valid_q));
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: tb/tb_epi_tracer_lci_queue.sv
// Directed and randomised bench for epi_tracer_lci_queue with a queue-based reference.
module tb_epi_tracer_lci_queue;
   import epi_tracer_pkg::*;

   localparam int DEPTH  = 16;
   localparam int PULL_W = 2;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int PN_W   = $clog2(PULL_W + 1);

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             flush_i = 1'b0;
   logic             push_i = 1'b0;
   logic             last_i = 1'b0;
   logic [PN_W-1:0]  pull_n_i = '0;
   logic [DEPTH-1:0] lci_vec_o;
   logic [DEPTH-1:0] valid_vec_o;
   logic [CNT_W-1:0] count_o;
   logic             full_o;
   logic             empty_o;
   logic [CNT_W-1:0] head_grp_len_o;
   logic [CNT_W-1:0] grp_cnt_o;
   logic             overflow_o;
   logic             underflow_o;

   typedef struct {
      logic [DEPTH-1:0] lci;
      logic [DEPTH-1:0] vld;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] hgl;
      logic [CNT_W-1:0] grp;
      logic             full;
      logic             empty;
      logic             ovf;
      logic             unf;
   } exp_t;

   exp_t sb[$];
   bit   mq[$];
   bit   m_ovf = 1'b0;
   bit   m_unf = 1'b0;
   int   checks = 0;
   int   failures = 0;

   epi_tracer_lci_queue #(
      .DEPTH  (DEPTH),
      .PULL_W (PULL_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .push_i         (push_i),
      .last_i         (last_i),
      .pull_n_i       (pull_n_i),
      .lci_vec_o      (lci_vec_o),
      .valid_vec_o    (valid_vec_o),
      .count_o        (count_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .head_grp_len_o (head_grp_len_o),
      .grp_cnt_o      (grp_cnt_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Build the expected output image from the reference queue contents.
   function automatic exp_t model_image();
      exp_t e;
      int   ones;
      e.lci = '0;
      e.vld = '0;
      e.hgl = '0;
      ones  = 0;
      for (int i = 0; i < mq.size(); i++) begin
         e.vld[i] = 1'b1;
         e.lci[i] = mq[i];
         if (mq[i]) begin
            ones++;
            if (e.hgl == '0) e.hgl = CNT_W'(i + 1);
         end
      end
      e.cnt   = CNT_W'(mq.size());
      e.grp   = CNT_W'(ones);
      e.full  = (mq.size() == DEPTH);
      e.empty = (mq.size() == 0);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      return e;
   endfunction

   // Advance the reference queue by one clock with the given inputs.
   task automatic model_step(input bit r, input bit f, input bit p, input bit l, input int pull);
      int pe;
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (f) begin
         mq.delete();
      end else begin
         pe = (pull < mq.size()) ? pull : mq.size();
         if (pull > mq.size()) m_unf = 1'b1;
         repeat (pe) void'(mq.pop_front());
         if (p) begin
            if (mq.size() < DEPTH) mq.push_back(l);
            else m_ovf = 1'b1;
         end
      end
   endtask

   // Drive one cycle, record the expectation, then compare after the edge.
   task automatic step(input bit r, input bit f, input bit p, input bit l, input int pull);
      exp_t e;
      rst_i    = r;
      flush_i  = f;
      push_i   = p;
      last_i   = l;
      pull_n_i = PN_W'(pull);
      model_step(r, f, p, l, pull);
      sb.push_back(model_image());
      @(posedge clk_i);
      #1;
      e = sb.pop_front();
      check("lci_vec",  32'(lci_vec_o),      32'(e.lci));
      check("valid_vec", 32'(valid_vec_o),   32'(e.vld));
      check("count",    32'(count_o),        32'(e.cnt));
      check("head_len", 32'(head_grp_len_o), 32'(e.hgl));
      check("grp_cnt",  32'(grp_cnt_o),      32'(e.grp));
      check("full",     32'(full_o),         32'(e.full));
      check("empty",    32'(empty_o),        32'(e.empty));
      check("overflow", 32'(overflow_o),     32'(e.ovf));
      check("underflow", 32'(underflow_o),   32'(e.unf));
   endtask

   initial begin
      // Reset state
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_empty", 32'(empty_o), 32'd1);

      // Five pushes 0,0,1,0,1
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      check("s1_lci",  32'(lci_vec_o[4:0]),  32'h14);
      check("s1_cnt",  32'(count_o),         32'd5);
      check("s1_hgl",  32'(head_grp_len_o),  32'd3);
      check("s1_grp",  32'(grp_cnt_o),       32'd2);

      // Pull two while pushing a last=1 entry
      step(0, 0, 1, 1, 2);
      check("s2_cnt", 32'(count_o),        32'd4);
      check("s2_lci", 32'(lci_vec_o[3:0]), 32'hD);
      check("s2_hgl", 32'(head_grp_len_o), 32'd1);

      // Fill to full, overflow, then push with pull while full
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
      check("s3_full", 32'(full_o), 32'd1);
      step(0, 0, 1, 1, 0);
      check("s3_ovf",  32'(overflow_o), 32'd1);
      check("s3_cnt",  32'(count_o),    32'd16);
      step(0, 0, 1, 1, 1);
      check("s3_cnt2", 32'(count_o),       32'd16);
      check("s3_tail", 32'(lci_vec_o[15]), 32'd1);
      check("s3_ovf2", 32'(overflow_o),    32'd1);

      // Over-pull from a single entry
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 2);
      check("s4_cnt",   32'(count_o),     32'd0);
      check("s4_empty", 32'(empty_o),     32'd1);
      check("s4_unf",   32'(underflow_o), 32'd1);

      // Flush beats a simultaneous push; sticky underflow survives the flush
      for (int i = 0; i < 7; i++) step(0, 0, 1, i[0], 0);
      check("s5_cnt7", 32'(count_o), 32'd7);
      step(0, 1, 1, 1, 1);
      check("s5_cnt",   32'(count_o),     32'd0);
      check("s5_valid", 32'(valid_vec_o), 32'd0);
      check("s5_unf",   32'(underflow_o), 32'd1);

      // Reset beats a push
      step(0, 0, 1, 1, 0);
      step(1, 0, 1, 1, 1);
      check("s6_cnt",   32'(count_o),        32'd0);
      check("s6_lci",   32'(lci_vec_o),      32'd0);
      check("s6_hgl",   32'(head_grp_len_o), 32'd0);
      check("s6_unf",   32'(underflow_o),    32'd0);
      check("s6_ovf",   32'(overflow_o),     32'd0);

      // Mixed random traffic, occasional flush
      for (int i = 0; i < 300; i++) begin
         step(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 1) == 1, int'($urandom_range(0, PULL_W)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
